// File: rtl/rca_mp_add_seq_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer.
//   WORD_W   : width of one slice handled by the shared ripple-carry adder
//   ST_*     : controller state encodings (IDLE, RUN, DONE)
package rca_mp_add_seq_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rca_16_bit.sv
// 16-bit ripple-carry adder: o_sum = i_a + i_b + i_cin, o_cout is bit 16.
// Ports:
//   i_a, i_b  16-bit addends
//   i_cin     carry into bit 0
//   o_sum     16-bit sum
//   o_cout    carry out of bit 15
module rca_16_bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [16:0] w_c;

  // One full adder per bit, carry rippling upward.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 16; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[16];
  end

endmodule

// File: rtl/rca_mp_add_seq.sv
// Multi-precision add/subtract sequencer. One rca_16_bit is reused over
// NUM_WORDS slices, least-significant first, with the carry held in a
// register between slices.
// Ports:
//   clk    system clock (rising edge)
//   rst    synchronous active-high reset
//   start  request pulse, accepted in IDLE or DONE
//   sub    0: a+b+cin   1: a-b (cin ignored)
//   cin    carry-in for add mode
//   a, b   W-bit operands (W = 16*NUM_WORDS), captured on accepted start
//   busy   high while slices are being processed
//   done   one-cycle pulse when sum/cout/ovf are valid
//   sum    W-bit result, stable from done until the next accepted start
//   cout   final carry (sub mode: 1 = no borrow)
//   ovf    signed overflow of the W-bit operation
module rca_mp_add_seq
  import rca_mp_add_seq_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        sub,
  input  logic                        cin,
  input  logic [WORD_W*NUM_WORDS-1:0] a,
  input  logic [WORD_W*NUM_WORDS-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W*NUM_WORDS-1:0] sum,
  output logic                        cout,
  output logic                        ovf
);

  localparam int W     = WORD_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic              r_sub;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [WORD_W-1:0] w_a_sl;
  logic [WORD_W-1:0] w_b_sl;
  logic [WORD_W-1:0] w_sum_sl;
  logic              w_cout_sl;
  logic              w_accept;
  logic              w_last;

  // Two's-complement overflow: both addends share a sign and the result
  // sign differs from it. b_msb is the effective (possibly inverted) b.
  function automatic logic f_ovf(input logic a_msb, input logic b_msb,
                                 input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_idx == LAST_IDX);

  // Slice select: subtraction is a + ~b + 1, the +1 entering as the
  // initial carry loaded on accept.
  assign w_a_sl = r_a[WORD_W*r_idx +: WORD_W];
  assign w_b_sl = r_sub ? ~r_b[WORD_W*r_idx +: WORD_W]
                        :  r_b[WORD_W*r_idx +: WORD_W];

  rca_16_bit u_rca (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sum_sl),
    .o_cout (w_cout_sl)
  );

  // Operand capture: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_sub <= sub;
    end
  end

  // Controller and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sum[WORD_W*r_idx +: WORD_W] <= w_sum_sl;
          r_carry <= w_cout_sl;
          if (w_last) begin
            // Park idx at 0 so the slice muxes never point past the top word.
            r_idx   <= '0;
            r_cout  <= w_cout_sl;
            r_ovf   <= f_ovf(w_a_sl[WORD_W-1], w_b_sl[WORD_W-1],
                             w_sum_sl[WORD_W-1]);
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_rca_mp_add_seq.sv
// Directed bench for rca_mp_add_seq: a 4-word and a 1-word instance.
module tb_rca_mp_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start4, sub4, cin4;
  logic [63:0] a4, b4;
  logic        busy4, done4, cout4, ovf4;
  logic [63:0] sum4;

  logic        start1, sub1, cin1;
  logic [15:0] a1, b1;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;

  int n_chk = 0;
  int n_err = 0;

  rca_mp_add_seq #(.NUM_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .cin(cin4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
    .cout(cout4), .ovf(ovf4)
  );

  rca_mp_add_seq #(.NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic go4(input logic [63:0] a, input logic [63:0] b,
                     input logic c, input logic s);
    a4 = a; b4 = b; cin4 = c; sub4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait4(output int cyc);
    cyc = 0;
    while (!done4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic op4(input string tag, input logic [63:0] a,
                     input logic [63:0] b, input logic c, input logic s,
                     input logic [63:0] es, input logic ec, input logic eo);
    int cyc;
    go4(a, b, c, s);
    wait4(cyc);
    check({tag, "_lat"},  64'(cyc),   64'd4);
    check({tag, "_sum"},  sum4,       es);
    check({tag, "_cout"}, 64'(cout4), 64'(ec));
    check({tag, "_ovf"},  64'(ovf4),  64'(eo));
    @(posedge clk); #1;
    check({tag, "_done1cyc"}, 64'(done4), 64'd0);
    check({tag, "_hold"},     sum4,       es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    rst = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_done4", 64'(done4), 64'd0);
    check("rst_sum4",  sum4,       64'd0);
    check("rst_cout4", 64'(cout4), 64'd0);
    check("rst_ovf4",  64'(ovf4),  64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_sum1",  64'(sum1),  64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-word instance.
    a1 = 16'hFEBF; b1 = 16'h5555; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("nw1_lat",  64'(cyc),   64'd1);
    check("nw1_sum",  64'(sum1),  64'h5414);
    check("nw1_cout", 64'(cout1), 64'd1);
    check("nw1_ovf",  64'(ovf1),  64'd0);

    // Carry chains, subtraction and signed overflow.
    op4("chain_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'd0, 1'b1, 1'b0);
    op4("chain_cin", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0,
        64'h0000_0000_0001_0000, 1'b0, 1'b0);
    op4("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1,
        64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op4("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1,
        64'd2, 1'b1, 1'b0);
    op4("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
        64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op4("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
        64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // start re-pulsed during RUN with different operands is ignored.
    go4(64'd7, 64'd5, 1'b0, 1'b1);
    @(posedge clk); #1;
    a4 = 64'hFFFF_FFFF_FFFF_FFFF; b4 = 64'h1234; cin4 = 1'b1; sub4 = 1'b0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait4(cyc);
    check("ign_lat",  64'(cyc),   64'd2);
    check("ign_sum",  sum4,       64'd2);
    check("ign_cout", 64'(cout4), 64'd1);
    @(posedge clk); #1;

    // Back-to-back: start in the DONE cycle goes straight to RUN.
    go4(64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0);
    wait4(cyc);
    check("b2b1_lat", 64'(cyc), 64'd4);
    check("b2b1_sum", sum4,     64'h0000_0000_0001_0000);
    a4 = 64'd5; b4 = 64'd7; cin4 = 1'b0; sub4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("b2b_busy", 64'(busy4), 64'd1);
    check("b2b_done", 64'(done4), 64'd0);
    wait4(cyc);
    check("b2b2_lat",  64'(cyc),   64'd4);
    check("b2b2_sum",  sum4,       64'hFFFF_FFFF_FFFF_FFFE);
    check("b2b2_cout", 64'(cout4), 64'd0);
    @(posedge clk); #1;

    // Reset during the second RUN cycle discards the operation.
    go4(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_busy", 64'(busy4), 64'd0);
    check("mrst_done", 64'(done4), 64'd0);
    check("mrst_sum",  sum4,       64'd0);
    check("mrst_cout", 64'(cout4), 64'd0);
    check("mrst_ovf",  64'(ovf4),  64'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done4) seen = 1;
    end
    check("mrst_nodone", 64'(seen), 64'd0);
    op4("after_rst", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
        1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
